stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit multiplexer with valid/ready handshaking and a registered output stage. Successor to the team's combinational 2:1 bit/byte muxes.
- Sits between multiple producers (register-file read ports, ALU result sources) and a single consumer.
- Channel selection is either explicit (`sel`) or round-robin arbitration, chosen at run time.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, 2, select/channel-index width; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle.
- sel  input  SEL_W  explicit channel select; used when rr_mode=0.
- rr_mode  input  1  1 = round-robin arbitration, 0 = explicit select.
- out_data  output  WIDTH  registered output data.
- out_chan  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer last_grant=CHANNELS-1, so channel 0 has first priority.
  - in_ready=0 while rst_n=0.
- Space signal: space = ~out_valid | out_ready. This is the output register being empty, or being drained this cycle.
- Grant, explicit mode (rr_mode=0), combinational:
  - gnt=sel if sel<CHANNELS and in_valid[sel]=1.
  - Otherwise no grant.
  - sel>=CHANNELS never grants and never raises in_ready.
- Grant, round-robin mode (rr_mode=1):
  - gnt is the first c with in_valid[c]=1, scanning from last_grant+1 upward with wrap-around modulo CHANNELS.
  - Scanning ends at last_grant itself, so a lone requester is re-granted every cycle.
- Handshake:
  - in_ready[gnt]=space. All other in_ready bits are 0.
  - A transfer occurs when in_valid[gnt] & in_ready[gnt].
  - On transfer: out_data<=in_data[gnt], out_chan<=gnt, out_valid<=1.
  - In rr_mode=1, last_grant<=gnt on transfer.
- Latency: 1 cycle from input acceptance to out_valid. Full throughput is 1 beat/cycle while out_ready=1.
- Output drain:
  - If out_valid & out_ready and no transfer occurs, out_valid<=0.
  - out_data and out_chan keep their last values (not cleared).
- Stall: while out_valid=1 and out_ready=0, out_data and out_chan are held stable and no input is accepted.
  - Changes to sel, rr_mode or in_valid during a stall do not affect the held beat.
- last_grant updates only on transfers in rr_mode=1.
  - Explicit-mode transfers and mode switches leave it unchanged.
  - A mode switch takes effect in the same cycle (grant logic is combinational).
- Reset mid-operation: a held beat is discarded (out_valid->0 immediately, asynchronously); the pointer returns to CHANNELS-1.
- Producer rule: producers must hold in_data/in_valid until their in_ready is seen. The block does not buffer unaccepted data.

Optional Feature:
- Macro: STREAM_MUX_COUNT_EN.
- When defined:
  - Adds output port xfer_count, 16 bits: count of accepted input transfers since reset.
  - Increments by 1 on each transfer and saturates at 16'hFFFF.
  - Reset value 0.
- When undefined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Explicit select: rr_mode=0, sel=2, in_valid=4'b0110, in_data ch2=8'hA5, out_ready=1.
  - Required: in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_chan=2.
- Round robin: rr_mode=1, all in_valid=1, data ch0..3 = 8'h10/8'h11/8'h12/8'h13, out_ready=1 for 6 cycles.
  - Required: out_chan sequence 0,1,2,3,0,1 with matching data.
  - Then drop in_valid[1]: next grants skip ch1.
- Backpressure: hold out_ready=0 with out_valid=1 for 3 cycles while changing sel and in_data.
  - Required: out_data/out_chan unchanged, in_ready=0.
  - Raise out_ready: the held beat drains and a new beat loads in the same cycle.
- Illegal select: CHANNELS=3, SEL_W=2, sel=3, in_valid=3'b111.
  - Required: in_ready=0, out_valid stays 0.
- Async reset mid-stall: assert rst_n=0 between clock edges while out_valid=1.
  - Required: out_valid=0, out_data=0 immediately.
  - After release with rr_mode=1 and all channels valid: first grant is ch0.
- With STREAM_MUX_COUNT_EN: after 5 transfers, xfer_count=5. A stalled cycle does not increment it.

Source files
------------

// File: rtl/stream_mux_rr_if.sv
// rtl/stream_mux_rr_if.sv - handshake/data bundle between the producers, the mux and its consumer
interface stream_mux_rr_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic                      rr_mode;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    // master: the producers/consumer side; slave: the mux itself
    modport master (
        output in_data, in_valid, sel, rr_mode, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, rr_mode, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel valid/ready mux, explicit or round-robin select, registered output
// Optional transfer counter port xfer_count enabled by STREAM_MUX_COUNT_EN.
module stream_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_mux_rr_if.slave    bus
`ifdef STREAM_MUX_COUNT_EN
    ,
    output logic [15:0]       xfer_count
`endif
);
    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic [SEL_W-1:0] out_chan_q,   out_chan_d;
    logic             out_valid_q,  out_valid_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic             space;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;

    assign space = ~out_valid_q | bus.out_ready;

    // Round-robin scan starts one past the last winner and ends on it, so a lone requester keeps winning.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        if (bus.rr_mode) begin
            for (int k = 1; k <= CHANNELS; k++) begin
                idx = SEL_W'((int'(last_grant_q) + k) % CHANNELS);
                if (!gnt_vld && bus.in_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt     = idx;
                end
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.sel == SEL_W'(c) && bus.in_valid[c]) begin
                    gnt_vld = 1'b1;
                    gnt     = SEL_W'(c);
                end
            end
        end
    end

    assign gnt_data = bus.in_data[gnt*WIDTH +: WIDTH];
    assign xfer     = gnt_vld & space & rst_n;

    always_comb begin
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            out_data_d  = gnt_data;
            out_chan_d  = gnt;
            out_valid_d = 1'b1;
            if (bus.rr_mode) begin
                last_grant_d = gnt;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_chan_q   <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= SEL_W'(CHANNELS - 1);
        end else begin
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;

`ifdef STREAM_MUX_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (xfer && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_count = cnt_q;
`endif
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - self-checking bench for stream_mux_rr (4-channel main instance, 3-channel select instance)
module tb_stream_mux_rr;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    stream_mux_rr_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) b1 ();
    stream_mux_rr_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) b2 ();

`ifdef STREAM_MUX_COUNT_EN
    logic [15:0] cnt1, cnt2;
`endif

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
`ifdef STREAM_MUX_COUNT_EN
        , .xfer_count(cnt1)
`endif
    );

    stream_mux_rr #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
`ifdef STREAM_MUX_COUNT_EN
        , .xfer_count(cnt2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model of the 4-channel instance
    function automatic int model_gnt(input logic [3:0] v, input int s, input logic rr, input int lg);
        if (!rr) return (s < 4 && v[s]) ? s : -1;
        for (int k = 1; k <= 4; k++) begin
            if (v[(lg + k) % 4]) return (lg + k) % 4;
        end
        return -1;
    endfunction

    logic       m_valid;
    logic [7:0] m_data;
    int         m_chan;
    int         m_lg;
    int         m_cnt;
    int         mg;
    logic       msp;

    always_comb mg  = model_gnt(b1.in_valid, int'(b1.sel), b1.rr_mode, m_lg);
    always_comb msp = !m_valid || b1.out_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_chan  <= 0;
            m_lg    <= 3;
            m_cnt   <= 0;
        end else if (mg >= 0 && msp) begin
            m_valid <= 1'b1;
            m_data  <= b1.in_data[mg*8 +: 8];
            m_chan  <= mg;
            if (b1.rr_mode) m_lg <= mg;
            if (m_cnt < 65535) m_cnt <= m_cnt + 1;
        end else if (m_valid && b1.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] er;
        if (!rst_n) er = 4'b0;
        else        er = (mg >= 0 && msp) ? 4'(1 << mg) : 4'b0;
        chk("model in_ready",  32'(b1.in_ready),  32'(er));
        chk("model out_valid", 32'(b1.out_valid), 32'(m_valid));
        chk("model out_data",  32'(b1.out_data),  32'(m_data));
        chk("model out_chan",  32'(b1.out_chan),  32'(m_chan));
`ifdef STREAM_MUX_COUNT_EN
        chk("model xfer_count", 32'(cnt1), 32'(m_cnt));
`endif
    end

    int rr_seq1 [6] = '{0, 1, 2, 3, 0, 1};
    int rr_seq2 [4] = '{2, 3, 0, 2};

    initial begin
        rst_n = 1'b0;
        b1.in_data = '0; b1.in_valid = '0; b1.sel = '0; b1.rr_mode = 1'b0; b1.out_ready = 1'b0;
        b2.in_data = '0; b2.in_valid = '0; b2.sel = '0; b2.rr_mode = 1'b0; b2.out_ready = 1'b0;
        b1.in_valid = 4'b1111;
        @(negedge clk);
        chk("reset out_valid", 32'(b1.out_valid), 0);
        chk("reset in_ready",  32'(b1.in_ready),  0);
        step(1);
        b1.in_valid = 4'b0000;
        rst_n = 1'b1;

        // illegal select on the 3-channel instance
        b2.sel = 2'd3; b2.in_valid = 3'b111; b2.in_data = 24'h332211; b2.out_ready = 1'b1;
        #1 chk("illegal sel in_ready", 32'(b2.in_ready), 0);
        step(2);
        chk("illegal sel out_valid", 32'(b2.out_valid), 0);
        b2.sel = 2'd2;
        #1 chk("sel2 of 3 in_ready", 32'(b2.in_ready), 32'h4);
        step(1);
        chk("sel2 of 3 out_valid", 32'(b2.out_valid), 1);
        chk("sel2 of 3 out_data",  32'(b2.out_data),  32'h33);
        b2.in_valid = 3'b000;

        // explicit select
        b1.rr_mode = 1'b0; b1.sel = 2'd2; b1.in_valid = 4'b0110;
        b1.in_data = 32'h13A5_1110; b1.out_ready = 1'b1;
        #1 chk("explicit in_ready", 32'(b1.in_ready), 32'h4);
        step(1);
        chk("explicit out_valid", 32'(b1.out_valid), 1);
        chk("explicit out_data",  32'(b1.out_data),  32'hA5);
        chk("explicit out_chan",  32'(b1.out_chan),  2);
        b1.in_valid = 4'b0000;
        step(2);
        chk("drain out_valid",   32'(b1.out_valid), 0);
        chk("drain data held",   32'(b1.out_data),  32'hA5);

        // round robin; explicit transfers must not have moved the pointer
        b1.rr_mode = 1'b1; b1.in_valid = 4'b1111; b1.in_data = 32'h1312_1110;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("rr out_chan", 32'(b1.out_chan), 32'(rr_seq1[i]));
            chk("rr out_data", 32'(b1.out_data), 32'(8'h10 + rr_seq1[i]));
        end
        b1.in_valid = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("rr skip out_chan", 32'(b1.out_chan), 32'(rr_seq2[i]));
        end

        // backpressure with a held beat from ch2
        b1.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b1.rr_mode = 1'b0; b1.sel = 2'(i); b1.in_data = $urandom;
            #1 chk("stall in_ready", 32'(b1.in_ready), 0);
            step(1);
            chk("stall out_chan", 32'(b1.out_chan), 2);
            chk("stall out_data", 32'(b1.out_data), 32'h12);
        end
        b1.sel = 2'd1; b1.in_valid = 4'b1111; b1.in_data = 32'h4433_2211; b1.out_ready = 1'b1;
        #1 chk("release in_ready", 32'(b1.in_ready), 32'h2);
        step(1);
        chk("release out_valid", 32'(b1.out_valid), 1);
        chk("release out_chan",  32'(b1.out_chan),  1);
        chk("release out_data",  32'(b1.out_data),  32'h22);

        // async reset in the middle of a stall
        b1.out_ready = 1'b0;
        step(1);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(b1.out_valid), 0);
        chk("async rst out_data",  32'(b1.out_data),  0);
        chk("async rst in_ready",  32'(b1.in_ready),  0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        b1.rr_mode = 1'b1; b1.in_valid = 4'b1111; b1.in_data = 32'h1312_1110; b1.out_ready = 1'b1;
        step(1);
        chk("post rst first chan", 32'(b1.out_chan), 0);
        chk("post rst first data", 32'(b1.out_data), 32'h10);
        step(4);
        b1.out_ready = 1'b0;
        step(2);
        chk("five xfers out_chan", 32'(b1.out_chan), 0);
`ifdef STREAM_MUX_COUNT_EN
        chk("xfer_count after stall", 32'(cnt1), 5);
`endif
        b1.in_valid = 4'b0000;
        b1.out_ready = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
